mem_arbiter: RTL and testbench

- Shares the single 256-bit off-chip memory port between the instruction-cache controller (requester 0) and the data-cache controller (requester 1).
- Sits between both cache controllers and the data memory model, at the CPU top-level boundary.
- Grants one requester at a time, forwards its request to memory, and routes mem_ack_i and read data back to it.
- Holds each grant for one complete memory transaction.

---
 rtl/mem_arbiter.sv | 111 +++++++++++
 tb/tb_mem_arbiter.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Two-requester arbiter for the shared cache-line memory port (icache = 0, dcache = 1).
// Optional macro MEM_ARB_RR_EN selects round-robin tie breaking instead of fixed dcache priority.
module mem_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 256
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              req0_enable_i,
    input  logic              req0_write_i,
    input  logic [ADDR_W-1:0] req0_addr_i,
    input  logic [DATA_W-1:0] req0_data_i,
    output logic              req0_ack_o,
    output logic [DATA_W-1:0] req0_data_o,
    input  logic              req1_enable_i,
    input  logic              req1_write_i,
    input  logic [ADDR_W-1:0] req1_addr_i,
    input  logic [DATA_W-1:0] req1_data_i,
    output logic              req1_ack_o,
    output logic [DATA_W-1:0] req1_data_o,
    output logic              mem_enable_o,
    output logic              mem_write_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_data_o,
    input  logic [DATA_W-1:0] mem_data_i,
    input  logic              mem_ack_i,
    output logic              busy_o
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GRANT0 = 2'd1,
        GRANT1 = 2'd2
    } state_t;

    state_t state;
    logic   last_grant;
    logic   tie_to_1;

`ifdef MEM_ARB_RR_EN
    always_comb tie_to_1 = ~last_grant;
`else
    // Fixed priority: the dcache wins every tie whatever the history.
    always_comb tie_to_1 = 1'b1 | last_grant;
`endif

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state      <= IDLE;
            last_grant <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (req0_enable_i && req1_enable_i)
                        state <= tie_to_1 ? GRANT1 : GRANT0;
                    else if (req1_enable_i)
                        state <= GRANT1;
                    else if (req0_enable_i)
                        state <= GRANT0;
                end
                GRANT0: begin
                    if (mem_ack_i) begin
                        state      <= IDLE;
                        last_grant <= 1'b0;
                    end
                end
                GRANT1: begin
                    if (mem_ack_i) begin
                        state      <= IDLE;
                        last_grant <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Memory side follows the granted requester; everything is quiet in IDLE.
    always_comb begin
        mem_enable_o = 1'b0;
        mem_write_o  = 1'b0;
        mem_addr_o   = '0;
        mem_data_o   = '0;
        req0_ack_o   = 1'b0;
        req1_ack_o   = 1'b0;
        busy_o       = 1'b0;
        case (state)
            GRANT0: begin
                mem_enable_o = 1'b1;
                mem_write_o  = req0_write_i;
                mem_addr_o   = req0_addr_i;
                mem_data_o   = req0_data_i;
                req0_ack_o   = mem_ack_i;
                busy_o       = 1'b1;
            end
            GRANT1: begin
                mem_enable_o = 1'b1;
                mem_write_o  = req1_write_i;
                mem_addr_o   = req1_addr_i;
                mem_data_o   = req1_data_i;
                req1_ack_o   = mem_ack_i;
                busy_o       = 1'b1;
            end
            default: ;
        endcase
    end

    assign req0_data_o = mem_data_i;
    assign req1_data_o = mem_data_i;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: a memory model acks after a set latency,
// a negedge monitor pops expected acks (requester id and read data) in order.
module tb_mem_arbiter;
    localparam int ADDR_W = 32;
    localparam int DATA_W = 256;

    logic              clk_i = 1'b0;
    logic              rst_i;
    logic              req0_enable_i, req0_write_i;
    logic [ADDR_W-1:0] req0_addr_i;
    logic [DATA_W-1:0] req0_data_i;
    logic              req0_ack_o;
    logic [DATA_W-1:0] req0_data_o;
    logic              req1_enable_i, req1_write_i;
    logic [ADDR_W-1:0] req1_addr_i;
    logic [DATA_W-1:0] req1_data_i;
    logic              req1_ack_o;
    logic [DATA_W-1:0] req1_data_o;
    logic              mem_enable_o, mem_write_o;
    logic [ADDR_W-1:0] mem_addr_o;
    logic [DATA_W-1:0] mem_data_o;
    logic [DATA_W-1:0] mem_data_i;
    logic              mem_ack_i;
    logic              busy_o;

    mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .req0_enable_i(req0_enable_i), .req0_write_i(req0_write_i),
        .req0_addr_i(req0_addr_i), .req0_data_i(req0_data_i),
        .req0_ack_o(req0_ack_o), .req0_data_o(req0_data_o),
        .req1_enable_i(req1_enable_i), .req1_write_i(req1_write_i),
        .req1_addr_i(req1_addr_i), .req1_data_i(req1_data_i),
        .req1_ack_o(req1_ack_o), .req1_data_o(req1_data_o),
        .mem_enable_o(mem_enable_o), .mem_write_o(mem_write_o),
        .mem_addr_o(mem_addr_o), .mem_data_o(mem_data_o),
        .mem_data_i(mem_data_i), .mem_ack_i(mem_ack_i),
        .busy_o(busy_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        int              id;
        bit              chk_data;
        logic [DATA_W-1:0] data;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    // Memory model controls and observations
    int                mem_lat = 10;
    logic [DATA_W-1:0] rd_pat = '0;
    int                stray_req = 0;
    int                stray_done = 0;
    logic              wr_seen;
    logic [ADDR_W-1:0] addr_seen;
    logic [DATA_W-1:0] wdata_seen;

    task automatic chk(input string name, input logic [DATA_W-1:0] got, input logic [DATA_W-1:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, want);
        end
    endtask

    task automatic push_exp(input int id, input bit chk_data, input logic [DATA_W-1:0] data);
        exp_t e;
        e.id = id;
        e.chk_data = chk_data;
        e.data = data;
        exp_q.push_back(e);
    endtask

    initial begin
        int cnt = 0;
        mem_ack_i  = 1'b0;
        mem_data_i = '0;
        wr_seen    = 1'b0;
        addr_seen  = '0;
        wdata_seen = '0;
        forever begin
            @(posedge clk_i);
            #1;
            if (rst_i) begin
                cnt = 0;
                mem_ack_i = 1'b0;
            end else if (mem_ack_i) begin
                mem_ack_i = 1'b0;
            end else if (stray_req != stray_done) begin
                stray_done = stray_req;
                mem_ack_i = 1'b1;
            end else if (mem_enable_o) begin
                cnt++;
                if (cnt >= mem_lat) begin
                    cnt = 0;
                    mem_ack_i  = 1'b1;
                    mem_data_i = rd_pat;
                    wr_seen    = mem_write_o;
                    addr_seen  = mem_addr_o;
                    wdata_seen = mem_data_o;
                end
            end
        end
    end

    // Monitor: every ack pops one expectation; the cycle after an ack must show no request.
    always @(negedge clk_i) begin
        bit   prev_ack;
        exp_t e;
        int   got;
        if (rst_i) begin
            prev_ack = 1'b0;
        end else begin
            if (prev_ack) begin
                checks++;
                if (mem_enable_o !== 1'b0) begin
                    errors++;
                    $display("FAIL gap: mem_enable_o=%b expected 0 after ack", mem_enable_o);
                end
            end
            if (req0_ack_o === 1'b1 || req1_ack_o === 1'b1) begin
                checks++;
                if (req0_ack_o === 1'b1 && req1_ack_o === 1'b1) begin
                    errors++;
                    $display("FAIL ack_both: req0_ack_o=1 req1_ack_o=1 expected one");
                end else if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL ack_unexpected: req0_ack_o=%b req1_ack_o=%b expected none", req0_ack_o, req1_ack_o);
                end else begin
                    e = exp_q.pop_front();
                    got = (req1_ack_o === 1'b1) ? 1 : 0;
                    if (got != e.id) begin
                        errors++;
                        $display("FAIL ack_order: got requester %0d expected %0d", got, e.id);
                    end else if (e.chk_data && ((got == 1 ? req1_data_o : req0_data_o) !== e.data)) begin
                        errors++;
                        $display("FAIL ack_data: got %0h expected %0h", (got == 1 ? req1_data_o : req0_data_o), e.data);
                    end
                end
                prev_ack = 1'b1;
            end else begin
                prev_ack = 1'b0;
            end
        end
    end

    // Called at a negedge; returns at the negedge where the matching ack is seen.
    task automatic req_txn(input int id, input bit wr, input logic [ADDR_W-1:0] addr,
                           input logic [DATA_W-1:0] wd, input bit keep);
        int n = 0;
        bit acked = 1'b0;
        if (id == 0) begin
            req0_enable_i = 1'b1; req0_write_i = wr; req0_addr_i = addr; req0_data_i = wd;
        end else begin
            req1_enable_i = 1'b1; req1_write_i = wr; req1_addr_i = addr; req1_data_i = wd;
        end
        while (!acked && n < 200) begin
            @(negedge clk_i);
            n++;
            acked = (id == 0) ? (req0_ack_o === 1'b1) : (req1_ack_o === 1'b1);
        end
        if (!acked) begin
            checks++;
            errors++;
            $display("FAIL timeout_req%0d: no ack after %0d cycles, expected ack", id, n);
        end
        if (!keep || !acked) begin
            if (id == 0) req0_enable_i = 1'b0;
            else         req1_enable_i = 1'b0;
        end
    endtask

    initial begin
        rst_i = 1'b1;
        req0_enable_i = 1'b0; req0_write_i = 1'b0; req0_addr_i = '0; req0_data_i = '0;
        req1_enable_i = 1'b0; req1_write_i = 1'b0; req1_addr_i = '0; req1_data_i = '0;
        repeat (2) @(negedge clk_i);
        chk("rst_mem_enable", mem_enable_o, 0);
        chk("rst_busy", busy_o, 0);
        chk("rst_mem_write", mem_write_o, 0);
        chk("rst_mem_addr", mem_addr_o, 0);
        chk("rst_ack0", req0_ack_o, 0);
        chk("rst_ack1", req1_ack_o, 0);
        rst_i = 1'b0;
        @(negedge clk_i);

        // Single read by icache
        mem_lat = 10;
        rd_pat = {32{8'hA5}};
        chk("rd_pre_enable", mem_enable_o, 0);
        push_exp(0, 1'b1, {32{8'hA5}});
        fork
            req_txn(0, 1'b0, 32'h0000_0040, '0, 1'b0);
            begin
                @(negedge clk_i);
                chk("rd_enable_latency", mem_enable_o, 1);
                chk("rd_write_low", mem_write_o, 0);
                chk("rd_addr", mem_addr_o, 32'h40);
                chk("rd_busy", busy_o, 1);
            end
        join
        @(negedge clk_i);
        chk("rd_busy_fall", busy_o, 0);

        // Single write by dcache
        mem_lat = 5;
        push_exp(1, 1'b0, '0);
        req_txn(1, 1'b1, 32'h0000_0200, {16{16'h1234}}, 1'b0);
        chk("wr_write_flag", wr_seen, 1);
        chk("wr_addr", addr_seen, 32'h200);
        chk("wr_data", wdata_seen, {16{16'h1234}});
        repeat (2) @(negedge clk_i);

        // Stray ack while idle
        stray_req++;
        @(negedge clk_i);
        chk("stray_mem_ack_seen", mem_ack_i, 1);
        chk("stray_ack0", req0_ack_o, 0);
        chk("stray_ack1", req1_ack_o, 0);
        chk("stray_busy", busy_o, 0);
        @(negedge clk_i);
        chk("stray_enable", mem_enable_o, 0);
        rd_pat = {8{32'hDEAD_BEEF}};
        mem_lat = 3;
        push_exp(0, 1'b1, {8{32'hDEAD_BEEF}});
        req_txn(0, 1'b0, 32'h0000_0080, '0, 1'b0);
        repeat (2) @(negedge clk_i);

        // Ties, starting from a fresh reset (last_grant = 1)
        rst_i = 1'b1;
        @(negedge clk_i);
        rst_i = 1'b0;
        @(negedge clk_i);
        mem_lat = 4;
        rd_pat = {4{64'h0123_4567_89AB_CDEF}};
`ifdef MEM_ARB_RR_EN
        push_exp(0, 1'b1, {4{64'h0123_4567_89AB_CDEF}});
        push_exp(1, 1'b1, {4{64'h0123_4567_89AB_CDEF}});
        push_exp(0, 1'b1, {4{64'h0123_4567_89AB_CDEF}});
        push_exp(1, 1'b1, {4{64'h0123_4567_89AB_CDEF}});
        fork
            begin
                req_txn(0, 1'b0, 32'h0000_1000, '0, 1'b1);
                req_txn(0, 1'b0, 32'h0000_1040, '0, 1'b0);
            end
            begin
                req_txn(1, 1'b0, 32'h0000_2000, '0, 1'b1);
                req_txn(1, 1'b0, 32'h0000_2040, '0, 1'b0);
            end
        join
`else
        push_exp(1, 1'b1, {4{64'h0123_4567_89AB_CDEF}});
        push_exp(0, 1'b1, {4{64'h0123_4567_89AB_CDEF}});
        fork
            req_txn(0, 1'b0, 32'h0000_1000, '0, 1'b0);
            req_txn(1, 1'b0, 32'h0000_2000, '0, 1'b0);
            begin
                @(negedge clk_i);
                chk("tie_first_addr", mem_addr_o, 32'h2000);
            end
        join
`endif
        repeat (2) @(negedge clk_i);

        // Reset in the middle of a GRANT0 transaction
        mem_lat = 50;
        req0_enable_i = 1'b1; req0_write_i = 1'b0; req0_addr_i = 32'h0000_0300;
        repeat (4) @(negedge clk_i);
        chk("rstmid_granted", mem_enable_o, 1);
        #2;
        rst_i = 1'b1;
        #1;
        chk("rstmid_enable_async", mem_enable_o, 0);
        chk("rstmid_busy_async", busy_o, 0);
        req0_enable_i = 1'b0;
        @(negedge clk_i);
        rst_i = 1'b0;
        repeat (3) @(negedge clk_i);
        chk("rstmid_idle_enable", mem_enable_o, 0);
        chk("rstmid_idle_busy", busy_o, 0);

        repeat (2) @(negedge clk_i);
        chk("scoreboard_drained", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
